// File: rtl/branch_pkg.sv
// Shared branch-control types and constants: opcode enum, default sizes, jump-target table.
// No logic; imported by branch_ctrl and its return-address stack.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEZ  = 3'd1,
        BR_BNZ  = 3'd2,
        BR_JMP  = 3'd3,
        BR_JAL  = 3'd4,
        BR_RET  = 3'd5,
        BR_HALT = 3'd6
    } br_op_t;

    localparam int T_DEF = 10;
    localparam int W_DEF = 8;
    localparam int L_DEF = 5;
    localparam int D_DEF = 4;

    // Entry i holds (21*i + 1) mod 256.
    localparam logic [W_DEF-1:0] JUMP_LUT [2**L_DEF] = '{
        8'h01, 8'h16, 8'h2B, 8'h40, 8'h55, 8'h6A, 8'h7F, 8'h94,
        8'hA9, 8'hBE, 8'hD3, 8'hE8, 8'hFD, 8'h12, 8'h27, 8'h3C,
        8'h51, 8'h66, 8'h7B, 8'h90, 8'hA5, 8'hBA, 8'hCF, 8'hE4,
        8'hF9, 8'h0E, 8'h23, 8'h38, 8'h4D, 8'h62, 8'h77, 8'h8C
    };

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; push/pop take effect on the edge, top/count/flags are combinational.
// Latency 0 on top; no backpressure: a push when full overwrites the oldest entry and raises ovf.
import branch_pkg::*;

module ras_stack #(
    parameter int W = W_DEF,
    parameter int D = D_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         push_dat,
    output logic [W-1:0]         top_dat,
    output logic [$clog2(D):0]   count,
    output logic                 ovf,
    output logic                 unf
);
    localparam int PW = $clog2(D);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = D[PW:0];

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          full;
    logic          empty;

    assign full    = (cnt_q == CNT_MAX);
    assign empty   = (cnt_q == '0);
    assign ovf     = push & full;
    assign unf     = pop & empty;
    assign count   = cnt_q;
    assign top_dat = mem_q[ptr_q - PTR_ONE];

    // ptr_q is the next free slot; when full it also addresses the oldest entry.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[ptr_q] = push_dat;
            ptr_d        = ptr_q + PTR_ONE;
            if (!full) cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch decode for fetch: zero flag, jump-target table, return stack and sticky halt.
// Latency 0 (outputs follow BrOp in the same cycle); no backpressure, fetch consumes every cycle.
import branch_pkg::*;

module branch_ctrl #(
    parameter int T = T_DEF,
    parameter int W = W_DEF,
    parameter int L = L_DEF,
    parameter int D = D_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [2:0]   BrOp,
    input  logic [L-1:0] LutIdx,
    input  logic         AluZero,
    input  logic         FlagWe,
    input  logic [T-1:0] ProgCtr_p1,
    output logic         BranchEZ,
    output logic         BranchNZ,
    output logic         BranchAlways,
    output logic         Zero,
    output logic         Done,
    output logic [W-1:0] Target,
    output logic         StackErr
);
    logic is_bez, is_bnz, is_jmp, is_jal, is_ret, is_halt;
    logic halt_q, halt_d;
    logic zero_q, zero_d;
    logic err_q,  err_d;
    logic done;
    logic ras_push, ras_pop, ras_ovf, ras_unf;
    logic [W-1:0]          ras_top;
    logic [$clog2(D):0]    ras_count;
    logic [W-1:0]          lut_dat;
    logic                  unused_pc_hi;

    assign is_bez  = (BrOp == BR_BEZ);
    assign is_bnz  = (BrOp == BR_BNZ);
    assign is_jmp  = (BrOp == BR_JMP);
    assign is_jal  = (BrOp == BR_JAL);
    assign is_ret  = (BrOp == BR_RET);
    assign is_halt = (BrOp == BR_HALT);

    // An empty-stack RET halts in its own cycle, so ras_unf feeds Done directly.
    assign ras_pop  = is_ret & ~halt_q;
    assign done     = halt_q | is_halt | ras_unf;
    assign ras_push = is_jal & ~done;

    ras_stack #(.W(W), .D(D)) u_ras (
        .clk      (Clk),
        .rst_n    (Reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_dat (ProgCtr_p1[W-1:0]),
        .top_dat  (ras_top),
        .count    (ras_count),
        .ovf      (ras_ovf),
        .unf      (ras_unf)
    );

    assign unused_pc_hi = ^ProgCtr_p1[T-1:W];
    assign lut_dat      = W'(JUMP_LUT[LutIdx]);

    assign BranchEZ     = is_bez & ~done;
    assign BranchNZ     = is_bnz & ~done;
    assign BranchAlways = (is_jmp | is_jal | (is_ret & (ras_count != '0))) & ~done;
    assign Target       = is_ret ? ras_top : lut_dat;
    assign Zero         = zero_q;
    assign Done         = done;
    assign StackErr     = err_q;

    always_comb begin
        halt_d = halt_q | is_halt | ras_unf;
        zero_d = (FlagWe & ~done) ? AluZero : zero_q;
        err_d  = err_q | ras_ovf | ras_unf;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            halt_q <= 1'b0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            halt_q <= halt_d;
            zero_q <= zero_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed scenarios then random traffic against a queue-based model.
import branch_pkg::*;

module tb_branch_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [2:0] BrOp = '0;
    logic [4:0] LutIdx = '0;
    logic       AluZero = 1'b0;
    logic       FlagWe = 1'b0;
    logic [9:0] ProgCtr_p1 = '0;
    logic       BranchEZ, BranchNZ, BranchAlways, Zero, Done, StackErr;
    logic [7:0] Target;

    branch_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .BrOp         (BrOp),
        .LutIdx       (LutIdx),
        .AluZero      (AluZero),
        .FlagWe       (FlagWe),
        .ProgCtr_p1   (ProgCtr_p1),
        .BranchEZ     (BranchEZ),
        .BranchNZ     (BranchNZ),
        .BranchAlways (BranchAlways),
        .Zero         (Zero),
        .Done         (Done),
        .Target       (Target),
        .StackErr     (StackErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       ez, nz, al, zero, done, err;
        logic [7:0] tgt;
        bit         tgt_chk;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    // Reference model state
    bit         m_halt, m_zero, m_err;
    logic [7:0] m_stk[$];

    function automatic logic [7:0] lut_of(input int i);
        return 8'((i * 21 + 1) % 256);
    endfunction

    task automatic model_reset();
        m_halt = 0; m_zero = 0; m_err = 0;
        m_stk.delete();
    endtask

    // Compute the outputs for the applied inputs, queue them, then advance the model past the edge.
    task automatic model_issue(input int op, input int idx, input bit alu, input bit fwe,
                               input logic [9:0] pc, input bit advance);
        exp_t e;
        int   sz = m_stk.size();
        bit   done;
        if (op == 7) op = 0;
        done      = m_halt || (op == BR_HALT) || (op == BR_RET && sz == 0);
        e.ez      = (op == BR_BEZ) && !done;
        e.nz      = (op == BR_BNZ) && !done;
        e.al      = ((op == BR_JMP) || (op == BR_JAL) || (op == BR_RET && sz > 0)) && !done;
        e.zero    = m_zero;
        e.done    = done;
        e.err     = m_err;
        e.tgt_chk = !(op == BR_RET && sz == 0);
        e.tgt     = (op == BR_RET && sz > 0) ? m_stk[sz-1] : lut_of(idx);
        e.id      = step_id;
        exp_q.push_back(e);
        if (!advance) return;
        if (!done) begin
            if (fwe) m_zero = alu;
            if (op == BR_JAL) begin
                if (sz == 4) begin
                    void'(m_stk.pop_front());
                    m_err = 1;
                end
                m_stk.push_back(pc[7:0]);
            end
            if (op == BR_RET) void'(m_stk.pop_back());
        end
        if (op == BR_HALT) m_halt = 1;
        if (op == BR_RET && sz == 0 && !m_halt) begin
            m_halt = 1;
            m_err  = 1;
        end
    endtask

    task automatic step(input int op, input int idx = 0, input bit alu = 0,
                        input bit fwe = 0, input logic [9:0] pc = 10'h0);
        @(posedge Clk);
        #1;
        step_id++;
        BrOp       = op[2:0];
        LutIdx     = idx[4:0];
        AluZero    = alu;
        FlagWe     = fwe;
        ProgCtr_p1 = pc;
        model_issue(op, idx, alu, fwe, pc, 1'b1);
    endtask

    // Reset is asserted between edges so the monitor sees its effect before any clock edge.
    task automatic do_reset();
        @(posedge Clk);
        #1;
        step_id++;
        Reset = 1'b0;
        BrOp = '0; FlagWe = 1'b0; AluZero = 1'b0; LutIdx = 5'd7;
        model_reset();
        model_issue(0, 7, 0, 0, 10'h0, 1'b0);
        @(posedge Clk);
        #1;
        step_id++;
        Reset = 1'b1;
        model_issue(0, 7, 0, 0, 10'h0, 1'b0);
    endtask

    task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, id, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("BranchEZ",     e.id, {7'b0, BranchEZ},     {7'b0, e.ez});
            chk("BranchNZ",     e.id, {7'b0, BranchNZ},     {7'b0, e.nz});
            chk("BranchAlways", e.id, {7'b0, BranchAlways}, {7'b0, e.al});
            chk("Zero",         e.id, {7'b0, Zero},         {7'b0, e.zero});
            chk("Done",         e.id, {7'b0, Done},         {7'b0, e.done});
            chk("StackErr",     e.id, {7'b0, StackErr},     {7'b0, e.err});
            if (e.tgt_chk) chk("Target", e.id, Target, e.tgt);
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        int r, op;
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;

        step(BR_NONE, 9);
        // Flag write then conditional branch on the registered flag
        step(BR_NONE, 0, 1, 1);
        step(BR_BEZ, 3);
        step(BR_NONE, 0, 0, 1);
        step(BR_BNZ, 3);
        // Flag write on the branch itself: branch sees the old flag
        step(BR_BNZ, 4, 1, 1);
        step(BR_BEZ, 4);

        // JAL / RET pair
        step(BR_JAL, 5, 0, 0, 10'h012);
        step(BR_NONE, 1);
        step(BR_RET, 2);
        step(BR_NONE, 0);

        // Overflow: five pushes into a depth-4 stack, then four pops
        for (int i = 1; i <= 5; i++) step(BR_JAL, i, 0, 0, 10'(i));
        for (int i = 0; i < 4; i++) step(BR_RET, i);
        step(BR_NONE, 0);

        // Mid-run reset with two entries, Zero set and halted
        step(BR_JAL, 1, 0, 0, 10'h3A1);
        step(BR_JAL, 2, 1, 1, 10'h2B2);
        step(BR_HALT, 3);
        step(BR_NONE, 4);
        do_reset();
        step(BR_NONE, 11);

        // Underflow on the now-empty stack halts in the same cycle
        step(BR_RET, 6);
        step(BR_JAL, 7, 1, 1, 10'h055);
        step(BR_RET, 8);
        step(BR_NONE, 0);
        do_reset();

        // HALT freezes flag and branches
        step(BR_NONE, 0, 1, 1);
        step(BR_HALT, 12, 0, 1);
        step(BR_NONE, 0, 0, 1);
        step(BR_NONE, 0, 1, 1);
        step(BR_JMP, 13);
        step(BR_BEZ, 14);
        do_reset();

        // Random traffic in short segments separated by resets
        for (int seg = 0; seg < 25; seg++) begin
            for (int n = 0; n < 60; n++) begin
                r = $urandom_range(0, 99);
                if      (r < 12) op = BR_NONE;
                else if (r < 26) op = BR_BEZ;
                else if (r < 40) op = BR_BNZ;
                else if (r < 50) op = BR_JMP;
                else if (r < 68) op = BR_JAL;
                else if (r < 88) op = BR_RET;
                else if (r < 90) op = BR_HALT;
                else if (r < 94) op = 7;
                else             op = BR_NONE;
                step(op, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
            end
            do_reset();
        end

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge Clk);
        @(posedge Clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
